// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache downstream port: line fills as LINE_WORDS-beat bursts after LATENCY idle cycles, writebacks with one ack beat.
// Optional critical-word-first read ordering under CACHE_MEM_RESPONDER_CWF_EN.
module cache_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_DEPTH  = 256,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wdata_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_last,
  output logic                resp_err,
  output logic                busy
);
  localparam int LW_W   = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int LINE_W = IDX_W - LW_W;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, WACK} state_t;

  state_t            state;
  logic [LINE_W-1:0] line_q;
  logic [LW_W-1:0]   start_q;
  logic [LW_W-1:0]   beat;
  logic [3:0]        lat_cnt;
  logic              err_q;
  logic              resp_valid_q, resp_last_q, resp_err_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-3:0] req_widx;
  logic              req_oor;
  logic [LW_W-1:0]   req_start;
  logic              accept, wr_hs, resp_hs;
  logic [LINE_W-1:0] rd_line;
  logic [LW_W-1:0]   rd_off;
  logic              rd_err;
  logic [DATA_W-1:0] rd_word;
  logic              unused_bits;

  assign req_widx = req_addr[ADDR_W-1:2];
  assign req_oor  = |req_widx[ADDR_W-3:IDX_W];
`ifdef CACHE_MEM_RESPONDER_CWF_EN
  assign req_start = req_widx[LW_W-1:0];
`else
  assign req_start = '0;
`endif
  assign unused_bits = ^{req_addr[1:0], req_widx[LW_W-1:0]};

  // Every output is forced low while rst is asserted, not just after the edge.
  assign req_ready   = (state == IDLE) & ~rst;
  assign wdata_ready = (state == WBURST) & ~rst;
  assign busy        = (state != IDLE) & ~rst;
  assign resp_valid  = resp_valid_q & ~rst;
  assign resp_last   = resp_last_q & ~rst;
  assign resp_err    = resp_err_q & ~rst;
  assign resp_data   = rst ? '0 : resp_data_q;

  assign accept  = req_valid & req_ready;
  assign wr_hs   = wdata_valid & wdata_ready;
  assign resp_hs = resp_valid & resp_ready;

  // Address of the word to load into resp_data at the coming edge.
  always_comb begin
    rd_line = line_q;
    rd_off  = start_q + beat + LW_W'(1);
    rd_err  = err_q;
    if (state == IDLE) begin
      rd_line = req_widx[IDX_W-1:LW_W];
      rd_off  = req_start;
      rd_err  = req_oor;
    end else if (state == WAIT) begin
      rd_off = start_q;
    end
    rd_word = rd_err ? '0 : mem[{rd_line, rd_off}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      line_q       <= '0;
      start_q      <= '0;
      beat         <= '0;
      lat_cnt      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          line_q  <= req_widx[IDX_W-1:LW_W];
          start_q <= req_start;
          err_q   <= req_oor;
          beat    <= '0;
          lat_cnt <= 4'(LATENCY);
          if (req_we) begin
            state <= WBURST;
          end else if (LATENCY == 0) begin
            state        <= RBURST;
            resp_valid_q <= 1'b1;
            resp_last_q  <= 1'b0;
            resp_err_q   <= req_oor;
            resp_data_q  <= rd_word;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt <= 4'd1) begin
            state        <= RBURST;
            resp_valid_q <= 1'b1;
            resp_last_q  <= 1'b0;
            resp_err_q   <= err_q;
            resp_data_q  <= rd_word;
          end
          lat_cnt <= lat_cnt - 4'd1;
        end
        RBURST: if (resp_hs) begin
          if (resp_last_q) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
          end else begin
            beat        <= beat + LW_W'(1);
            resp_data_q <= rd_word;
            resp_last_q <= (beat == LW_W'(LINE_WORDS - 2));
          end
        end
        WBURST: if (wr_hs) begin
          beat <= beat + LW_W'(1);
          if (beat == LW_W'(LINE_WORDS - 1)) begin
            state        <= WACK;
            resp_valid_q <= 1'b1;
            resp_last_q  <= 1'b1;
            resp_err_q   <= err_q;
            resp_data_q  <= '0;
          end
        end
        WACK: if (resp_hs) begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          resp_last_q  <= 1'b0;
          resp_err_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backing store is never reset; out-of-range writebacks are dropped.
  always_ff @(posedge clk) begin
    if (state == WBURST && wr_hs && !err_q) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wdata_be[i]) mem[{line_q, beat}][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: fills, stalls, writebacks, range errors, mid-burst reset, word ordering.
module tb_cache_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wdata_be;
  logic        resp_valid, resp_ready, resp_last, resp_err, busy;
  logic [31:0] resp_data;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_mem_responder #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .MEM_DEPTH(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wdata_be(wdata_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic we, input logic [31:0] addr, output int acc);
    int w = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    while (req_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    acc       = cyc;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic read_line(input string tag, input logic [31:0] addr, input logic [3:0] pat,
                           input logic [3:0][31:0] exp, input logic exp_err);
    int acc;
    int n = 0;
    int t = 0;
    bit seen = 0;
    send_req(1'b0, addr, acc);
    while (n < 4 && t < 100) begin
      resp_ready = pat[t % 4];
      @(negedge clk);
      if (resp_valid) begin
        if (!seen) begin
          seen = 1;
          check({tag, "_lat"}, 32'(cyc - acc), 32'(LAT));
        end
        check({tag, "_data"}, resp_data, exp[n]);
        check({tag, "_last"}, {31'd0, resp_last}, {31'd0, n == 3});
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        if (resp_ready) n++;
      end
      @(posedge clk); #1;
      t++;
    end
    resp_ready = 1'b0;
    check({tag, "_beats"}, 32'(n), 32'd4);
    @(negedge clk);
    check({tag, "_done_vld"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_done_rdy"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic write_line(input string tag, input logic [31:0] addr, input logic [3:0][31:0] dat,
                            input logic [3:0][3:0] be, input logic exp_err);
    int acc;
    int w;
    int t = 0;
    send_req(1'b1, addr, acc);
    for (int b = 0; b < 4; b++) begin
      wdata_valid = 1'b1;
      wdata       = dat[b];
      wdata_be    = be[b];
      w = 0;
      while (wdata_ready !== 1'b1 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      check({tag, "_wrdy"}, {31'd0, wdata_ready}, 32'd1);
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    resp_ready  = 1'b1;
    @(negedge clk);
    while (resp_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_ack_vld"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_ack_data"}, resp_data, 32'd0);
    check({tag, "_ack_last"}, {31'd0, resp_last}, 32'd1);
    check({tag, "_ack_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ack_done"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [3:0][31:0] p, e, wv, q, z;
    logic [3:0][3:0]  full, part;
    int acc;
    int n;
    int t;

    p[0] = 32'hFF0000FF; p[1] = 32'hF0F0F0F0; p[2] = 32'h00FFFF00; p[3] = 32'h00FF00FF;
    wv[0] = 32'h11111111; wv[1] = 32'h22222222; wv[2] = 32'h33333333; wv[3] = 32'h44444444;
    q[0] = 32'hA0A0A0A0; q[1] = 32'hB1B1B1B1; q[2] = 32'hC2C2C2C2; q[3] = 32'hD3D3D3D3;
    z = '0;
    full = {4'hF, 4'hF, 4'hF, 4'hF};
    part = {4'hF, 4'hF, 4'h3, 4'hF};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    wdata_valid = 1'b0; wdata = '0; wdata_be = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    write_line("pre", 32'h1F0, p, full, 1'b0);
    read_line("t1", 32'h1F0, 4'b1111, p, 1'b0);
    read_line("t2", 32'h1F0, 4'b1001, p, 1'b0);

    // Reset while beat 2 of a fill is on the bus.
    send_req(1'b0, 32'h1F0, acc);
    resp_ready = 1'b1;
    n = 0;
    t = 0;
    while (n < 2 && t < 50) begin
      @(negedge clk);
      if (resp_valid) n++;
      @(posedge clk); #1;
      t++;
    end
    check("t5_pre_beats", 32'(n), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_vld", {31'd0, resp_valid}, 32'd0);
    check("t5_rst_data", resp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    check("t5_after_busy", {31'd0, busy}, 32'd0);
    check("t5_after_vld", {31'd0, resp_valid}, 32'd0);
    check("t5_after_last", {31'd0, resp_last}, 32'd0);
    check("t5_after_rdy", {31'd0, req_ready}, 32'd1);
    read_line("t5", 32'h1F0, 4'b1111, p, 1'b0);

`ifdef CACHE_MEM_RESPONDER_CWF_EN
    e[0] = p[2]; e[1] = p[3]; e[2] = p[0]; e[3] = p[1];
`else
    e = p;
`endif
    read_line("t6", 32'h1F8, 4'b1111, e, 1'b0);

    write_line("t3w", 32'h1F0, wv, part, 1'b0);
    e = wv;
    e[1] = 32'hF0F02222;
    read_line("t3r", 32'h1F0, 4'b1111, e, 1'b0);

    write_line("pre0", 32'h000, q, full, 1'b0);
    read_line("t4r", 32'h400, 4'b1111, z, 1'b1);
    write_line("t4w", 32'h400, wv, full, 1'b1);
    read_line("t4c", 32'h000, 4'b1111, q, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
